// File: rtl/rps_pkg.sv
// Shared encodings and defaults for the RPS replay sequencer.
package rps_pkg;

    // Move encodings
    localparam logic [1:0] ROCK     = 2'b00;
    localparam logic [1:0] SCISSORS = 2'b01;
    localparam logic [1:0] PAPER    = 2'b10;

    // Replay sequencer states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        WAIT   = 3'd2,
        WRITE  = 3'd3,
        RECORD = 3'd4
    } replay_state_e;

    localparam int unsigned DEF_HIST_DEPTH    = 60;
    localparam int unsigned DEF_THETA_LATENCY = 100;

endpackage

// File: rtl/rps_latency_timer.sv
// Loadable down-counter that times the theta datapath latency.
module rps_latency_timer #(
    parameter int unsigned CNT_W = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             count,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Load takes priority; counting stops at zero
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (count && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/rps_replay_sequencer.sv
// Replays stored rounds through the theta datapath, then records the new round.
module rps_replay_sequencer
    import rps_pkg::*;
#(
    parameter int unsigned HIST_DEPTH    = DEF_HIST_DEPTH,
    parameter int unsigned ADDR_W        = 6,
    parameter int unsigned THETA_LATENCY = DEF_THETA_LATENCY,
    parameter int unsigned CNT_W         = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        rand_move,
    input  logic [1:0]        hist_user_rd,
    output logic [ADDR_W-1:0] hist_rd_addr,
    output logic [ADDR_W-1:0] t_idx,
    output logic [ADDR_W-1:0] rew_idx,
    output logic [1:0]        row_sel,
    output logic              theta_we,
    output logic              hist_we,
    output logic [ADDR_W-1:0] game,
    output logic              busy,
    output logic              ready,
    output logic              full
);

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_SELECT = SELECT;
    localparam logic [2:0] S_WAIT   = WAIT;
    localparam logic [2:0] S_WRITE  = WRITE;
    localparam logic [2:0] S_RECORD = RECORD;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic              timer_zero;
    logic [ADDR_W-1:0] t_idx_inc;

    assign t_idx_inc = t_idx + ADDR_W'(1);

    rps_latency_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (state == S_SELECT),
        .load_val (CNT_W'(THETA_LATENCY - 1)),
        .count    (state == S_WAIT),
        .zero     (timer_zero)
    );

    // Next-state decode; start is only honoured in IDLE, so requests while busy are dropped
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start && !full) begin
                    state_nxt = (game != '0) ? S_SELECT : S_RECORD;
                end
            end
            S_SELECT: state_nxt = S_WAIT;
            S_WAIT: begin
                if (timer_zero) begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE:  state_nxt = (t_idx_inc == game) ? S_RECORD : S_SELECT;
            S_RECORD: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State, replay index, row select and round count; row_sel/t_idx hold through WAIT
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            t_idx   <= '0;
            row_sel <= 2'b00;
            game    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_SELECT: row_sel <= (t_idx == '0) ? rand_move : hist_user_rd;
                S_WRITE:  t_idx <= t_idx_inc;
                S_RECORD: begin
                    t_idx <= '0;
                    if (!full) begin
                        game <= game + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes decode straight from the state register, so they are one clean cycle each
    always_comb begin
        theta_we     = (state == S_WRITE);
        hist_we      = (state == S_RECORD);
        busy         = (state != S_IDLE);
        full         = (game == ADDR_W'(HIST_DEPTH));
        ready        = (state == S_IDLE) && !full;
        hist_rd_addr = (t_idx == '0) ? '0 : (t_idx - ADDR_W'(1));
        rew_idx      = game - t_idx - ADDR_W'(1);
    end

endmodule

// File: tb/tb_rps_replay_sequencer.sv
// Scoreboard bench for rps_replay_sequencer with a short latency and a 4-deep history.
module tb_rps_replay_sequencer;

    localparam int DEPTH = 4;
    localparam int LAT   = 4;
    localparam int STEP  = LAT + 2;
    localparam int AW    = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    rand_move = 2'b00;
    logic [1:0]    hist_user_rd;
    logic [AW-1:0] hist_rd_addr, t_idx, rew_idx, game;
    logic [1:0]    row_sel;
    logic          theta_we, hist_we, busy, ready, full;

    typedef struct {
        int kind;  // 0 = theta write, 1 = history write
        int t;
        int rew;
        int row;
        int cyc;
    } ev_t;

    ev_t        sb[$];
    ev_t        mon_e;
    logic [1:0] user_mem [0:7];
    logic [1:0] cur_user = 2'b00;
    int         cyc = 0;
    int         model_game = 0;
    int         n_checks = 0;
    int         n_pass = 0;

    rps_replay_sequencer #(
        .HIST_DEPTH    (DEPTH),
        .ADDR_W        (AW),
        .THETA_LATENCY (LAT),
        .CNT_W         (3)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .rand_move    (rand_move),
        .hist_user_rd (hist_user_rd),
        .hist_rd_addr (hist_rd_addr),
        .t_idx        (t_idx),
        .rew_idx      (rew_idx),
        .row_sel      (row_sel),
        .theta_we     (theta_we),
        .hist_we      (hist_we),
        .game         (game),
        .busy         (busy),
        .ready        (ready),
        .full         (full)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Combinational user-history memory
    assign hist_user_rd = user_mem[hist_rd_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor: pop expected strobes and compare
    always @(negedge clock) begin
        if (!reset) begin
            if (theta_we && hist_we) check("both_strobes", 1, 0);
            if (theta_we) begin
                if (sb.size() == 0) begin
                    check("unexpected_theta_we", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("theta_kind", 0, mon_e.kind);
                    check("t_idx", t_idx, mon_e.t);
                    check("rew_idx", rew_idx, mon_e.rew);
                    check("row_sel", row_sel, mon_e.row);
                    check("hist_rd_addr", hist_rd_addr, (mon_e.t == 0) ? 0 : mon_e.t - 1);
                    check("theta_cycle", cyc, mon_e.cyc);
                end
            end
            if (hist_we) begin
                if (sb.size() == 0) begin
                    check("unexpected_hist_we", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("hist_kind", 1, mon_e.kind);
                    check("hist_addr", game, mon_e.t);
                    check("hist_cycle", cyc, mon_e.cyc);
                end
                user_mem[game] = cur_user;
            end
        end
    end

    // mode: 0 plain, 1 re-pulse start while busy, 2 async reset mid-WAIT
    task automatic do_round(input logic [1:0] rm, input logic [1:0] usr, input int mode);
        int  g;
        int  c0;
        bit  done;
        ev_t e;
        @(negedge clock);
        g         = model_game;
        c0        = cyc + 1;
        start     = 1'b1;
        rand_move = rm;
        cur_user  = usr;
        for (int k = 0; k < g; k++) begin
            e.kind = 0;
            e.t    = k;
            e.rew  = g - k - 1;
            e.row  = (k == 0) ? int'(rm) : int'(user_mem[k-1]);
            e.cyc  = c0 + STEP * k + LAT + 1;
            sb.push_back(e);
        end
        e.kind = 1; e.t = g; e.rew = 0; e.row = 0; e.cyc = c0 + STEP * g;
        sb.push_back(e);
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            start = (mode == 1) && (cyc == c0 + 3);
            if (mode == 2 && cyc == c0 + 3) begin
                #2 reset = 1'b1;
                #1;
                check("rst_busy", busy, 0);
                check("rst_ready", ready, 1);
                check("rst_game", game, 0);
                check("rst_t_idx", t_idx, 0);
                check("rst_row_sel", row_sel, 0);
                check("rst_theta_we", theta_we, 0);
                sb.delete();
                model_game = 0;
                repeat (2) @(negedge clock);
                reset = 1'b0;
                return;
            end
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        check("round_done", done, 1);
        check("ready_cycle", cyc, c0 + STEP * g + 1);
        if (model_game < DEPTH) model_game++;
        check("game", game, model_game);
        check("full", full, model_game == DEPTH);
        check("ready", ready, model_game < DEPTH);
        check("sb_empty", sb.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) user_mem[i] = 2'b00;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset_ready", ready, 1);
        check("reset_busy", busy, 0);
        check("reset_game", game, 0);
        check("reset_theta_we", theta_we, 0);
        check("reset_hist_we", hist_we, 0);
        check("reset_full", full, 0);

        do_round(2'b00, 2'b10, 0);  // game 0: record only
        do_round(2'b10, 2'b10, 0);
        do_round(2'b00, 2'b00, 1);  // start re-pulsed while busy
        do_round(2'b01, 2'b00, 0);  // game 3: rows 01,10,10

        // Start while full is ignored
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("full_busy", busy, 0);
        check("full_ready", ready, 0);
        repeat (20) @(negedge clock);
        check("full_game", game, DEPTH);
        check("full_flag", full, 1);
        check("full_sb_empty", sb.size(), 0);

        // Reset clears full, then a reset mid-WAIT drops the pending write
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        sb.delete();
        model_game = 0;
        do_round(2'b10, 2'b01, 0);
        do_round(2'b01, 2'b01, 2);
        do_round(2'b00, 2'b10, 0);  // behaves as game 0 again

        repeat (2) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
